life_array_host: RTL and testbench

// - Host-side master for the 16-bit windowed port of the 8x8 life array: drives vali/vali_selector/write_enb/step, reads valo via valo_selector.
// - Accepts whole-frame commands (64 cells) over a valid/ready handshake and returns one response beat per command.
// - Sits between the board controller/UART front end and one 8x8 array tile; boundary inputs (n,e,s,w,nw,ne,se,sw) are driven elsewhere.

---
 rtl/life_pkg.sv | 23 ++
 rtl/life_popcount64.sv | 16 +
 rtl/life_array_host.sv | 177 +++++++++++++++++
 tb/tb_life_array_host.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// Shared encodings for the 8x8 life array host: command opcodes, FSM states, frame geometry.
package life_pkg;

    localparam int WORDS   = 4;
    localparam int WORD_W  = 16;
    localparam int FRAME_W = 64;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_STEP = 2'b01,
        OP_READ = 2'b10,
        OP_RUN  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STEP,
        ST_READ,
        ST_RESP
    } state_e;

endpackage

// File: rtl/life_popcount64.sv
// Combinational population count of a 64-bit frame (0..64 live cells).
module life_popcount64
    import life_pkg::*;
(
    input  logic [FRAME_W-1:0] frame,
    output logic [6:0]         count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < FRAME_W; i++) begin
            count = count + 7'(frame[i]);
        end
    end

endmodule

// File: rtl/life_array_host.sv
// Host master for the 16-bit windowed port of an 8x8 life array tile.
// Optional live-cell count of the returned frame is built when LIFE_HOST_POPCOUNT_EN is defined.
module life_array_host
    import life_pkg::*;
#(
    parameter int READ_LAT = 0,
    parameter int STEP_GAP = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [FRAME_W-1:0] cmd_frame,
    input  logic [7:0]         cmd_gens,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [FRAME_W-1:0] rsp_frame,
    output logic [6:0]         rsp_alive,
    output logic [WORD_W-1:0]  arr_vali,
    output logic [1:0]         arr_vali_sel,
    output logic               arr_write_enb,
    input  logic [WORD_W-1:0]  arr_valo,
    output logic [1:0]         arr_valo_sel,
    output logic               arr_step
);

    localparam logic [1:0] LAT = 2'(READ_LAT);
    localparam logic [7:0] GAP = 8'(STEP_GAP);

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [7:0]         gen_cnt_q, gen_cnt_d;
    logic [7:0]         gap_cnt_q, gap_cnt_d;
    logic [1:0]         word_idx_q, word_idx_d;
    logic [1:0]         lat_cnt_q, lat_cnt_d;
    logic [FRAME_W-1:0] rsp_frame_q, rsp_frame_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_LOAD;
            frame_q     <= '0;
            gen_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            word_idx_q  <= '0;
            lat_cnt_q   <= '0;
            rsp_frame_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            frame_q     <= frame_d;
            gen_cnt_q   <= gen_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            word_idx_q  <= word_idx_d;
            lat_cnt_q   <= lat_cnt_d;
            rsp_frame_q <= rsp_frame_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        frame_d       = frame_q;
        gen_cnt_d     = gen_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        word_idx_d    = word_idx_q;
        lat_cnt_d     = lat_cnt_q;
        rsp_frame_d   = rsp_frame_q;
        cmd_ready     = 1'b0;
        rsp_valid     = 1'b0;
        arr_vali      = '0;
        arr_vali_sel  = '0;
        arr_write_enb = 1'b0;
        arr_valo_sel  = '0;
        arr_step      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_d       = op_e'(cmd_op);
                    frame_d    = cmd_frame;
                    gen_cnt_d  = cmd_gens;
                    gap_cnt_d  = '0;
                    word_idx_d = '0;
                    lat_cnt_d  = '0;
                    case (op_e'(cmd_op))
                        OP_LOAD: state_d = ST_LOAD;
                        OP_READ: state_d = ST_READ;
                        OP_STEP: state_d = (cmd_gens == 8'd0) ? ST_RESP : ST_STEP;
                        default: state_d = (cmd_gens == 8'd0) ? ST_READ : ST_STEP;
                    endcase
                end
            end

            ST_LOAD: begin
                arr_write_enb = 1'b1;
                arr_vali_sel  = word_idx_q;
                arr_vali      = frame_q[{word_idx_q, 4'b0000} +: WORD_W];
                word_idx_d    = word_idx_q + 2'd1;
                if (word_idx_q == 2'd3) begin
                    state_d = ST_RESP;
                end
            end

            // gap_cnt_q == 0 marks a pulse cycle; nonzero counts down the idle gap after it
            ST_STEP: begin
                if (gap_cnt_q == 8'd0) begin
                    arr_step  = 1'b1;
                    gen_cnt_d = gen_cnt_q - 8'd1;
                    if (GAP == 8'd0) begin
                        if (gen_cnt_q == 8'd1) begin
                            state_d = (op_q == OP_RUN) ? ST_READ : ST_RESP;
                        end
                    end else begin
                        gap_cnt_d = GAP;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                    if (gap_cnt_q == 8'd1 && gen_cnt_q == 8'd0) begin
                        state_d = (op_q == OP_RUN) ? ST_READ : ST_RESP;
                    end
                end
            end

            ST_READ: begin
                arr_valo_sel = word_idx_q;
                if (lat_cnt_q == LAT) begin
                    rsp_frame_d[{word_idx_q, 4'b0000} +: WORD_W] = arr_valo;
                    lat_cnt_d  = '0;
                    word_idx_d = word_idx_q + 2'd1;
                    if (word_idx_q == 2'd3) begin
                        state_d = ST_RESP;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q + 2'd1;
                end
            end

            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign rsp_frame = rsp_frame_q;

`ifdef LIFE_HOST_POPCOUNT_EN
    logic [6:0] alive_d;
    logic [6:0] alive_q;

    life_popcount64 u_popcount (
        .frame (rsp_frame_d),
        .count (alive_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alive_q <= '0;
        end else begin
            alive_q <= alive_d;
        end
    end

    assign rsp_alive = alive_q;
`else
    assign rsp_alive = '0;
`endif

endmodule

// File: tb/tb_life_array_host.sv
// Directed bench for life_array_host driving a behavioural 8x8 life array with a 2-cycle read delay.
module tb_life_array_host;
    import life_pkg::*;

    localparam int READ_LAT = 2;
    localparam int STEP_GAP = 1;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [63:0] cmd_frame;
    logic [7:0]  cmd_gens;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_frame;
    logic [6:0]  rsp_alive;
    logic [15:0] arr_vali;
    logic [1:0]  arr_vali_sel;
    logic        arr_write_enb;
    logic [15:0] arr_valo;
    logic [1:0]  arr_valo_sel;
    logic        arr_step;

    int checks = 0;
    int errors = 0;
    int overlap_cnt = 0;

    logic [63:0] cells;
    logic [15:0] rd_pipe1;
    logic [15:0] rd_pipe2;
    logic [6:0]  alive_three;
    logic [63:0] load_frame;

    life_array_host #(
        .READ_LAT (READ_LAT),
        .STEP_GAP (STEP_GAP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_frame     (cmd_frame),
        .cmd_gens      (cmd_gens),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_frame     (rsp_frame),
        .rsp_alive     (rsp_alive),
        .arr_vali      (arr_vali),
        .arr_vali_sel  (arr_vali_sel),
        .arr_write_enb (arr_write_enb),
        .arr_valo      (arr_valo),
        .arr_valo_sel  (arr_valo_sel),
        .arr_step      (arr_step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Conway rule with dead cells beyond the 8x8 edge
    function automatic logic [63:0] life_next(input logic [63:0] c);
        logic [63:0] n;
        int          cnt;
        n = '0;
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 8; k++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dk = -1; dk <= 1; dk++) begin
                        if ((dr != 0 || dk != 0) && r + dr >= 0 && r + dr < 8 && k + dk >= 0 && k + dk < 8) begin
                            cnt += int'(c[8 * (r + dr) + (k + dk)]);
                        end
                    end
                end
                n[8 * r + k] = (cnt == 3) || (c[8 * r + k] && cnt == 2);
            end
        end
        return n;
    endfunction

    // Array tile model: write/step on the clock edge, read data delayed READ_LAT cycles
    always @(posedge clk) begin
        if (arr_write_enb) begin
            cells[{arr_vali_sel, 4'b0000} +: 16] <= arr_vali;
        end else if (arr_step) begin
            cells <= life_next(cells);
        end
        rd_pipe1 <= cells[{arr_valo_sel, 4'b0000} +: 16];
        rd_pipe2 <= rd_pipe1;
    end
    assign arr_valo = rd_pipe2;

    always @(negedge clk) begin
        if (arr_write_enb && arr_step) overlap_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents a command in the current cycle (T) and returns in cycle T+1
    task automatic apply_stimulus(input op_e op, input logic [63:0] frame, input logic [7:0] gens);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_frame = frame;
        cmd_gens  = gens;
        check_output("accept_ready", 64'(cmd_ready), 64'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic take_response();
        check_output("rsp_valid_before_take", 64'(rsp_valid), 64'd1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_output("idle_ready", 64'(cmd_ready), 64'd1);
        check_output("idle_rsp_valid", 64'(rsp_valid), 64'd0);
    endtask

    initial begin
`ifdef LIFE_HOST_POPCOUNT_EN
        alive_three = 7'd3;
`else
        alive_three = 7'd0;
`endif
        cells     = '0;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_frame = '0;
        cmd_gens  = '0;
        rsp_ready = 1'b0;
        #11 reset = 1'b0;
        #1;
        check_output("rst_write_enb", 64'(arr_write_enb), 64'd0);
        check_output("rst_step", 64'(arr_step), 64'd0);
        check_output("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_output("rst_vali", 64'(arr_vali), 64'd0);
        check_output("rst_selectors", 64'({arr_vali_sel, arr_valo_sel}), 64'd0);
        check_output("rst_rsp_frame", rsp_frame, 64'd0);
        check_output("rst_alive", 64'(rsp_alive), 64'd0);
        check_output("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        tick();

        $display("[TB] LOAD horizontal blinker");
        load_frame = 64'h0000_0000_0038_0000;
        apply_stimulus(OP_LOAD, load_frame, 8'd0);
        for (int k = 0; k < 4; k++) begin
            check_output("load_write_enb", 64'(arr_write_enb), 64'd1);
            check_output("load_vali_sel", 64'(arr_vali_sel), 64'(k));
            check_output("load_vali", 64'(arr_vali), 64'(load_frame[16 * k +: 16]));
            check_output("load_step_low", 64'(arr_step), 64'd0);
            check_output("load_cmd_ready", 64'(cmd_ready), 64'd0);
            tick();
        end
        check_output("load_write_done", 64'(arr_write_enb), 64'd0);
        take_response();

        $display("[TB] RUN gens=1");
        apply_stimulus(OP_RUN, 64'd0, 8'd1);
        check_output("run_pulse", 64'(arr_step), 64'd1);
        tick();
        check_output("run_gap", 64'(arr_step), 64'd0);
        tick();
        for (int i = 0; i < 12; i++) begin
            check_output("run_valo_sel", 64'(arr_valo_sel), 64'(i / 3));
            check_output("run_no_rsp", 64'(rsp_valid), 64'd0);
            check_output("run_no_step", 64'(arr_step), 64'd0);
            tick();
        end
        check_output("run_rsp_valid", 64'(rsp_valid), 64'd1);
        check_output("run_frame_vertical", rsp_frame, 64'h0000_0000_1010_1000);
        check_output("run_alive", 64'(rsp_alive), 64'(alive_three));
        take_response();

        $display("[TB] STEP gens=0");
        apply_stimulus(OP_STEP, 64'd0, 8'd0);
        check_output("step0_no_pulse", 64'(arr_step), 64'd0);
        check_output("step0_rsp_valid", 64'(rsp_valid), 64'd1);
        check_output("step0_frame_held", rsp_frame, 64'h0000_0000_1010_1000);
        take_response();

        $display("[TB] STEP gens=3");
        apply_stimulus(OP_STEP, 64'd0, 8'd3);
        for (int i = 0; i < 6; i++) begin
            check_output("step3_pulse_pattern", 64'(arr_step), 64'((i % 2) == 0));
            check_output("step3_no_write", 64'(arr_write_enb), 64'd0);
            check_output("step3_no_rsp", 64'(rsp_valid), 64'd0);
            tick();
        end
        check_output("step3_rsp_valid", 64'(rsp_valid), 64'd1);
        take_response();

        $display("[TB] READ with delayed array");
        apply_stimulus(OP_READ, 64'd0, 8'd0);
        for (int i = 0; i < 12; i++) begin
            check_output("read_valo_sel", 64'(arr_valo_sel), 64'(i / 3));
            check_output("read_no_rsp", 64'(rsp_valid), 64'd0);
            tick();
        end
        check_output("read_rsp_valid", 64'(rsp_valid), 64'd1);
        check_output("read_frame_horizontal", rsp_frame, 64'h0000_0000_0038_0000);
        check_output("read_alive", 64'(rsp_alive), 64'(alive_three));

        $display("[TB] response stall with a pending command");
        load_frame = 64'h0123_4567_89AB_CDEF;
        cmd_valid  = 1'b1;
        cmd_op     = OP_LOAD;
        cmd_frame  = load_frame;
        cmd_gens   = 8'd0;
        for (int i = 0; i < 10; i++) begin
            check_output("stall_rsp_valid", 64'(rsp_valid), 64'd1);
            check_output("stall_frame", rsp_frame, 64'h0000_0000_0038_0000);
            check_output("stall_cmd_ready", 64'(cmd_ready), 64'd0);
            check_output("stall_no_write", 64'(arr_write_enb), 64'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_output("stall_release_ready", 64'(cmd_ready), 64'd1);
        check_output("stall_release_no_write", 64'(arr_write_enb), 64'd0);
        tick();
        cmd_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_output("second_load_enb", 64'(arr_write_enb), 64'd1);
            check_output("second_load_sel", 64'(arr_vali_sel), 64'(k));
            check_output("second_load_vali", 64'(arr_vali), 64'(load_frame[16 * k +: 16]));
            tick();
        end
        take_response();

        $display("[TB] reset during LOAD word 2");
        apply_stimulus(OP_LOAD, 64'hFFFF_FFFF_FFFF_FFFF, 8'd0);
        tick();
        tick();
        check_output("abort_word2_enb", 64'(arr_write_enb), 64'd1);
        check_output("abort_word2_sel", 64'(arr_vali_sel), 64'd2);
        #2 reset = 1'b1;
        #1;
        check_output("abort_write_enb", 64'(arr_write_enb), 64'd0);
        check_output("abort_vali_sel", 64'(arr_vali_sel), 64'd0);
        check_output("abort_cmd_ready", 64'(cmd_ready), 64'd1);
        #3 reset = 1'b0;
        tick();
        check_output("post_abort_write_enb", 64'(arr_write_enb), 64'd0);
        check_output("post_abort_rsp_valid", 64'(rsp_valid), 64'd0);
        check_output("post_abort_cmd_ready", 64'(cmd_ready), 64'd1);

        check_output("write_step_overlap", 64'(overlap_cnt), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
